uart_tx: RTL and testbench

- UART transmitter; the transmit counterpart to the existing UART receiver in the same IP. Runs on the 100 MHz system clock.
- Accepts one byte per valid/ready handshake from the register block or a FIFO. Serialises it on TX as 8N1: start bit, 8 data bits LSB first, one stop bit.
- Supports the same 8 baud selections as the receiver, so a looped-back TX/RX pair interoperates.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divisor table.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DIV_W = 14;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
`endif

    // Maps the 3-bit baud select (000=9600 .. 111=921600) to the terminal count N.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return DIV_W'(10416);
            3'd1:    return DIV_W'(5208);
            3'd2:    return DIV_W'(2604);
            3'd3:    return DIV_W'(1736);
            3'd4:    return DIV_W'(868);
            3'd5:    return DIV_W'(434);
            3'd6:    return DIV_W'(217);
            default: return DIV_W'(108);
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..div and wraps, pulsing bit_end on the last count.
// Shared with the UART receiver.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == div) ? '0 : cnt_q + DIV_W'(1);
        end
    end

    assign bit_end = en && (cnt_q == div);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN to insert a
// parity bit (even, or odd when parity_odd=1) between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_en,
    input  logic [2:0]           baud_tx_sel,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_dat,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_state_t            state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   tx_q, tx_d;
    logic                   accept;
    logic                   bit_end;
    logic                   cnt_en;
    logic                   cnt_clr;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    uart_baud_gen u_baud_gen (
        .clock   (clock),
        .reset   (reset),
        .en      (cnt_en),
        .clr     (cnt_clr),
        .div     (div_q),
        .bit_end (bit_end)
    );

    // Next-state, datapath and next-TX logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        cnt_clr   = 1'b0;
        cnt_en    = (state_q != IDLE);
        tx_ready  = uart_en && (state_q == IDLE) && !reset;
        accept    = tx_valid && tx_ready;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (accept) begin
                    state_d   = START;
                    shift_d   = tx_dat;
                    div_d     = baud_div(baud_tx_sel);
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = (^tx_dat) ^ parity_odd;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disabling the transmitter abandons the frame immediately.
        if (!uart_en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            cnt_clr   = 1'b1;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign TX      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = (state_q == STOP) && bit_end && uart_en && !reset;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx against a bit-level frame model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       uart_en;
    logic [2:0] baud_tx_sel;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_dat;
    logic       parity_odd;
    logic       TX;
    logic       tx_busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int div_tab [8] = '{10416, 5208, 2604, 1736, 868, 434, 217, 108};

    always #5 clock = ~clock;

    uart_tx #(.DATA_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_en     (uart_en),
        .baud_tx_sel (baud_tx_sel),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_dat      (tx_dat),
`ifdef UART_TX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .TX          (TX),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit idx: start, data LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] d, input logic po, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return (^d) ^ po;
`endif
        return 1'b1;
    endfunction

    task automatic do_accept(input logic [7:0] d, input logic [2:0] s, input logic po, input bit keep);
        int w;
        tx_dat = d; baud_tx_sel = s; parity_odd = po; tx_valid = 1'b1;
        #1;
        w = 0;
        while (!tx_ready && w < 20) begin
            @(negedge clock); #1;
            w++;
        end
        check("accept_ready", tx_ready, 1);
        @(posedge clock); #1;
        if (!keep) begin
            tx_valid    = 1'b0;
            tx_dat      = 8'($urandom);
            baud_tx_sel = 3'($urandom);
            parity_odd  = 1'($urandom);
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input int n, input logic po);
        int good, busy, rdy, dones, dpos;
        busy = 0; rdy = 0; dones = 0; dpos = -1;
        for (int b = 0; b < FRAME_BITS; b++) begin
            good = 0;
            for (int c = 0; c <= n; c++) begin
                @(negedge clock);
                if (TX === exp_bit(d, po, b)) good++;
                if (tx_busy === 1'b1) busy++;
                if (tx_ready !== 1'b0) rdy++;
                if (tx_done === 1'b1) begin
                    dones++;
                    dpos = b * (n + 1) + c;
                end
            end
            check($sformatf("bit%0d_cycles_d%02h", b, d), good, n + 1);
        end
        check("busy_cycles", busy, FRAME_BITS * (n + 1));
        check("ready_in_frame", rdy, 0);
        check("done_count", dones, 1);
        check("done_pos", dpos, FRAME_BITS * (n + 1) - 1);
    endtask

    task automatic check_idle(input logic ready_exp);
        @(negedge clock);
        check("idle_tx", TX, 1);
        check("idle_busy", tx_busy, 0);
        check("idle_done", tx_done, 0);
        check("idle_ready", tx_ready, ready_exp);
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic po);
        do_accept(d, s, po, 1'b0);
        check_frame(d, div_tab[s], po);
        check_idle(1'b1);
    endtask

    task automatic run_cycles(input int n, output int dones, output int rdy, output int lows);
        dones = 0; rdy = 0; lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (tx_done === 1'b1) dones++;
            if (tx_ready !== 1'b0) rdy++;
            if (TX !== 1'b1) lows++;
        end
    endtask

    initial begin
        int dones, rdy, lows, low, gap;
        bit run;
        logic [7:0] d;
        logic [2:0] s;
        logic po;

        reset = 1'b1; uart_en = 1'b1; tx_valid = 1'b0; tx_dat = 8'h00;
        baud_tx_sel = 3'd7; parity_odd = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_tx", TX, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_ready", tx_ready, 0);

        reset = 1'b0; uart_en = 1'b0;
        #1 check("en_off_ready", tx_ready, 0);
        @(negedge clock);
        check("en_off_tx", TX, 1);
        uart_en = 1'b1;
        #1 check("en_on_ready", tx_ready, 1);

        // Single frame at 921600.
        send(8'hA5, 3'd7, 1'b0);

        // Back-to-back with tx_valid held high.
        do_accept(8'h00, 3'd6, 1'b0, 1'b1);
        tx_dat = 8'hFF;
        check_frame(8'h00, div_tab[6], 1'b0);
        @(negedge clock);
        check("b2b_gap_tx", TX, 1);
        check("b2b_gap_busy", tx_busy, 0);
        check("b2b_gap_ready", tx_ready, 1);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        check_frame(8'hFF, div_tab[6], 1'b0);
        check_idle(1'b1);

        // Abort during data bit 3.
        do_accept(8'h3C, 3'd7, 1'b0, 1'b0);
        run_cycles(4 * 109 + 50, dones, rdy, lows);
        check("abort_pre_done", dones, 0);
        uart_en = 1'b0;
        @(negedge clock);
        check("abort_tx", TX, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_ready", tx_ready, 0);
        run_cycles(1200, dones, rdy, lows);
        check("abort_done", dones, 0);
        check("abort_ready_cnt", rdy, 0);
        check("abort_tx_low", lows, 0);
        uart_en = 1'b1;
        send(8'h55, 3'd7, 1'b0);

        // Reset during the stop bit.
        do_accept(8'h81, 3'd7, 1'b0, 1'b0);
        run_cycles(9 * 109 + 30, dones, rdy, lows);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_tx", TX, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_done", tx_done, 0);
        check("midrst_ready", tx_ready, 0);
        reset = 1'b0;
        send(8'($urandom), 3'd7, 1'($urandom));

        // Baud select changed mid-frame is ignored.
        do_accept(8'hC3, 3'd7, 1'b0, 1'b0);
        baud_tx_sel = 3'd0;
        check_frame(8'hC3, div_tab[7], 1'b0);
        check_idle(1'b1);

        // Start-bit length for every divisor (data LSB forced high to end the run).
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom) | 8'h01;
            s = 3'(k);
            do_accept(d, s, 1'b0, 1'b0);
            low = 0; run = 1'b1;
            while (run && low < 11000) begin
                @(negedge clock);
                if (TX === 1'b0) low++;
                else run = 1'b0;
            end
            check($sformatf("start_len_sel%0d", k), low, div_tab[k] + 1);
            uart_en = 1'b0;
            @(negedge clock);
            check($sformatf("start_abort_tx_sel%0d", k), TX, 1);
            uart_en = 1'b1;
        end

        // Random frames at the two fastest rates with random idle gaps.
        repeat (10) begin
            d   = 8'($urandom);
            s   = 3'($urandom_range(6, 7));
            po  = 1'($urandom);
            gap = $urandom_range(0, 5);
            repeat (gap) @(negedge clock);
            send(d, s, po);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
